normalize_round_fpu: RTL and testbench

NORMALIZE_ROUND_FPU -- requirements
Module: normalize_round_fpu

---
 rtl/normalize_round_fpu.sv | 108 ++++++++++
 tb/tb_normalize_round_fpu.sv | 100 ++++++++++
 2 files changed

// File: rtl/normalize_round_fpu.sv
// normalize_round_fpu: normalizes a raw half-precision sum and rounds it to nearest-even
module normalize_round_fpu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [4:0]  exp_in,
    input  logic [11:0] man_in,
    input  logic        guard_in,
    input  logic        sticky_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        flag_ovf,
    output logic        flag_unf,
    output logic        flag_inx,
    output logic        flag_zero
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t state, state_nx;
    logic [5:0] exp, e0, exp_f;
    logic [11:0] man, m;
    logic [3:0] cnt;
    logic [4:0] ef;
    logic [9:0] frac;
    logic [15:0] res_nx;
    logic g, s, sign, up, sub, ovf, inx, zero_in;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    always_comb begin
        e0 = (exp_in == 5'd0) ? 6'd1 : {1'b0, exp_in};
        zero_in = man_in == 12'd0 && !guard_in && !sticky_in;
        up = g & (s | man[0]);
        m = {1'b0, man[10:0]} + {11'd0, up};
        exp_f = m[11] ? exp + 6'd1 : exp;
        frac = m[11] ? 10'd0 : m[9:0];
        sub = exp_f == 6'd1 && !m[10];
        ef = sub ? 5'd0 : exp_f[4:0];
        ovf = exp_f >= 6'd31;
        inx = g | s | ovf;
        res_nx = ovf ? {sign, 5'h1F, 10'h0} : {sign, ef, frac};
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = !in_valid ? IDLE : zero_in ? DONE :
                              (man_in[11] || man_in[10] || e0 == 6'd1) ? ROUND : NORM;
            NORM:  state_nx = (man[9] || exp == 6'd2 || cnt == 4'd9) ? ROUND : NORM;
            ROUND: state_nx = DONE;
            DONE:  state_nx = out_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            exp <= '0;
            man <= '0;
            cnt <= '0;
            g <= 1'b0;
            s <= 1'b0;
            sign <= 1'b0;
            result <= '0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_inx <= 1'b0;
            flag_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    sign <= sign_in;
                    cnt <= '0;
                    if (zero_in) begin
                        result <= {sign_in, 15'h0};
                        {flag_ovf, flag_unf, flag_inx, flag_zero} <= 4'b0001;
                    end
                    // A carry out of the adder is absorbed here so ROUND only sees [10:0]
                    if (man_in[11]) begin
                        man <= man_in >> 1;
                        g <= man_in[0];
                        s <= guard_in | sticky_in;
                        exp <= e0 + 6'd1;
                    end else begin
                        man <= man_in;
                        g <= guard_in;
                        s <= sticky_in;
                        exp <= e0;
                    end
                end
                NORM: begin
                    man <= {man[10:0], g};
                    g <= s;
                    exp <= exp - 6'd1;
                    cnt <= cnt + 4'd1;
                end
                ROUND: begin
                    result <= res_nx;
                    flag_ovf <= ovf;
                    flag_unf <= ef == 5'd0 && inx && !ovf;
                    flag_inx <= inx;
                    flag_zero <= res_nx[14:0] == 15'd0;
                end
                DONE: ;
            endcase
        end
    end
endmodule

// File: tb/tb_normalize_round_fpu.sv
// tb_normalize_round_fpu: directed vectors with hand-computed results for normalize_round_fpu
module tb_normalize_round_fpu;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, sign_in = 1'b0;
    logic [4:0] exp_in = '0;
    logic [11:0] man_in = '0;
    logic guard_in = 1'b0, sticky_in = 1'b0, out_valid, out_ready = 1'b0;
    logic [15:0] result;
    logic flag_ovf, flag_unf, flag_inx, flag_zero;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    normalize_round_fpu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .man_in(man_in),
        .guard_in(guard_in), .sticky_in(sticky_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flag_ovf(flag_ovf),
        .flag_unf(flag_unf), .flag_inx(flag_inx), .flag_zero(flag_zero)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask
    task automatic offer(input logic sg, input logic [4:0] e, input logic [11:0] mn,
                         input logic gi, input logic si);
        @(negedge clk);
        chk("ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        sign_in = sg;
        exp_in = e;
        man_in = mn;
        guard_in = gi;
        sticky_in = si;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask
    // flags are packed {ovf, unf, inx, zero}; el < 0 skips the latency check
    task automatic run(input string tag, input logic sg, input logic [4:0] e,
                       input logic [11:0] mn, input logic gi, input logic si,
                       input logic [15:0] er, input logic [3:0] ef, input int el,
                       input int hold);
        int lat;
        offer(sg, e, mn, gi, si);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        if (el >= 0) chk({tag, "_latency"}, lat, el);
        chk({tag, "_result"}, result, er);
        chk({tag, "_flags"}, {flag_ovf, flag_unf, flag_inx, flag_zero}, ef);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_ready"}, in_ready, 0);
            chk({tag, "_hold_result"}, result, er);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_release_valid"}, out_valid, 0);
        chk({tag, "_release_ready"}, in_ready, 1);
        chk({tag, "_idle_result"}, result, er);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("reset_result", result, 0);
        chk("reset_flags", {flag_ovf, flag_unf, flag_inx, flag_zero}, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_ready", in_ready, 1);
        run("one",      0, 15, 12'h400, 0, 0, 16'h3C00, 4'b0000, 1, 0);
        run("carry",    0, 15, 12'h800, 0, 0, 16'h4000, 4'b0000, 1, 0);
        run("ovf",      0, 30, 12'h800, 0, 0, 16'h7C00, 4'b1010, 1, 0);
        run("norm2",    0, 15, 12'h100, 0, 0, 16'h3400, 4'b0000, 3, 0);
        run("rnd_up",   0, 15, 12'h401, 1, 0, 16'h3C02, 4'b0010, 1, 0);
        run("rnd_even", 0, 15, 12'h400, 1, 0, 16'h3C00, 4'b0010, 1, 5);
        run("subn",     0, 2,  12'h100, 0, 0, 16'h0200, 4'b0000, 2, 0);
        run("zero_neg", 1, 10, 12'h000, 0, 0, 16'h8000, 4'b0001, -1, 0);
        run("unf",      0, 1,  12'h001, 1, 0, 16'h0002, 4'b0110, 1, 0);
        run("exp0",     0, 0,  12'h001, 1, 0, 16'h0002, 4'b0110, 1, 0);
        run("rnd_carry",0, 15, 12'h7FF, 1, 1, 16'h4000, 4'b0010, 1, 0);
        run("neg_one",  1, 15, 12'h400, 0, 0, 16'hBC00, 4'b0000, 1, 0);
        offer(0, 15, 12'h001, 0, 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_norm_valid", out_valid, 0);
        chk("rst_norm_ready", in_ready, 1);
        chk("rst_norm_result", result, 0);
        @(negedge clk) rst = 1'b0;
        run("after_rst", 0, 15, 12'h800, 0, 0, 16'h4000, 4'b0000, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
